line_xfer_ctrl: RTL and testbench

- Sequences cache-line transfers between the OtterCache data array (256-bit lines) and the 32-bit main-memory bus.
- On a miss, optionally writes back the dirty victim line as 8 word writes, then fetches the new line as 8 word reads and assembles it.
- Owns the word index and address generation.
- Sits between the cache FSM (miss request/done) and the memory-side word port.

---
 rtl/line_xfer_pkg.sv | 27 ++
 rtl/line_xfer_ctrl_word_ctr.sv | 27 ++
 rtl/line_xfer_ctrl.sv | 126 ++++++++++++
 tb/tb_line_xfer_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_xfer_pkg.sv
// Shared types and sizing helpers for the cache line transfer controller.
package line_xfer_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} xfer_state_t;

  // Default geometry: 8 x 32-bit words per line, 32-bit byte addresses.
  localparam int unsigned DEF_LINE_WORDS = 8;
  localparam int unsigned DEF_WORD_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 32;

  localparam int unsigned WORD_BYTES = DEF_WORD_W / 8;
  localparam int unsigned LINE_BYTES = DEF_LINE_WORDS * WORD_BYTES;
  localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W      = $clog2(DEF_LINE_WORDS);

  // Byte-offset bits within a line for an arbitrary geometry.
  function automatic int unsigned offset_w(input int unsigned line_words,
                                           input int unsigned word_w);
    return $clog2(line_words * word_w / 8);
  endfunction

  // Word index width for an arbitrary geometry.
  function automatic int unsigned idx_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/line_xfer_ctrl_word_ctr.sv
// Word index counter shared by the writeback and fill phases.
module xfer_word_ctr #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  // Index register; wraps to 0 naturally after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign last = (idx == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/line_xfer_ctrl.sv
// Sequences victim writeback and line fill between the cache data array
// and a word-wide memory port.
module line_xfer_ctrl
  import line_xfer_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [ADDR_W-1:0]            fill_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] wb_line,
  output logic                         busy,
  output logic                         done,
  output logic [LINE_WORDS*WORD_W-1:0] fill_line,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  input  logic [WORD_W-1:0]            mem_rdata,
  input  logic                         mem_ack
);

  localparam int unsigned WBYTES = WORD_W / 8;
  localparam int unsigned OFFS_W = offset_w(LINE_WORDS, WORD_W);
  localparam int unsigned CTR_W  = idx_w(LINE_WORDS);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFFS_W) - ADDR_W'(1));

  xfer_state_t state_q, state_d;

  logic [ADDR_W-1:0]            wb_base_q, fill_base_q;
  logic [LINE_WORDS*WORD_W-1:0] wb_line_q, fill_line_q;
  logic [CTR_W-1:0]             idx;
  logic                         last;
  logic                         active;
  logic [ADDR_W-1:0]            word_off;

  assign active   = (state_q == WB) || (state_q == FILL);
  assign word_off = ADDR_W'(idx) * ADDR_W'(WBYTES);

  xfer_word_ctr #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (CTR_W)
  ) u_word_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .en    (active && mem_ack),
    .idx   (idx),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request context; bases are aligned to the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_base_q   <= '0;
      fill_base_q <= '0;
      wb_line_q   <= '0;
    end else if (state_q == IDLE && req) begin
      wb_base_q   <= wb_addr & BASE_MASK;
      fill_base_q <= fill_addr & BASE_MASK;
      wb_line_q   <= wb_line;
    end
  end

  // Assemble the fetched line one word per acknowledged read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_line_q <= '0;
    end else if (state_q == FILL && mem_ack) begin
      fill_line_q[idx*WORD_W +: WORD_W] <= mem_rdata;
    end
  end

  assign fill_line = fill_line_q;

  // Next-state and memory-port outputs.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = wb_en ? WB : FILL;
      end
      WB: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_base_q + word_off;
        mem_wdata = wb_line_q[idx*WORD_W +: WORD_W];
        if (mem_ack && last) state_d = FILL;
      end
      FILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = fill_base_q + word_off;
        if (mem_ack && last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Scoreboard bench for line_xfer_ctrl: stimulus pushes expected memory
// words and lines, a negedge monitor pops and compares them.
module tb_line_xfer_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         wb_en = 1'b0;
  logic [31:0]  wb_addr = '0;
  logic [31:0]  fill_addr = '0;
  logic [255:0] wb_line = '0;
  logic         busy, done, mem_req, mem_we;
  logic [255:0] fill_line;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack = 1'b0;
  logic [31:0]  rd_base = 32'h1000_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t         exp_q[$];
  logic [255:0] line_q[$];
  txn_t         mon_e;
  int           n_cmp = 0;
  int           n_err = 0;
  int           ack_mode = 0;
  int           stall_cnt = 0;
  int           done_cnt = 0;
  int           lat, wbc, d0;

  line_xfer_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .fill_addr (fill_addr),
    .wb_line   (wb_line),
    .busy      (busy),
    .done      (done),
    .fill_line (fill_line),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Memory model: read word i of a line returns rd_base + i.
  assign mem_rdata = rd_base + {29'd0, mem_addr[4:2]};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ack driver: mode 0 acks every cycle, mode 1 stalls 3 cycles per word.
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) begin
      mem_ack = 1'b1;
    end else if (mem_req) begin
      mem_ack   = (stall_cnt == 3);
      stall_cnt = mem_ack ? 0 : stall_cnt + 1;
    end else begin
      mem_ack   = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: compare every presented word (stalled or accepted) and every done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          check("mem_req_unexpected", {255'd0, mem_req}, 256'd0);
        end else begin
          mon_e = exp_q[0];
          check(mem_ack ? "mem_we" : "stall_mem_we", {255'd0, mem_we}, {255'd0, mon_e.we});
          check(mem_ack ? "mem_addr" : "stall_mem_addr", {224'd0, mem_addr}, {224'd0, mon_e.addr});
          if (mon_e.we)
            check(mem_ack ? "mem_wdata" : "stall_mem_wdata", {224'd0, mem_wdata},
                  {224'd0, mon_e.data});
          if (mem_ack) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (line_q.size() == 0) check("done_unexpected", {255'd0, done}, 256'd0);
        else check("fill_line", fill_line, line_q.pop_front());
      end
    end
  end

  task automatic push_xfer(input logic wb, input logic [31:0] wa, input logic [31:0] fa,
                           input logic [255:0] line, input logic [31:0] rb);
    txn_t t;
    logic [255:0] l;
    if (wb) begin
      for (int i = 0; i < 8; i++) begin
        t.we = 1'b1; t.addr = (wa & 32'hFFFF_FFE0) + 32'(4 * i); t.data = line[i*32 +: 32];
        exp_q.push_back(t);
      end
    end
    for (int i = 0; i < 8; i++) begin
      t.we = 1'b0; t.addr = (fa & 32'hFFFF_FFE0) + 32'(4 * i); t.data = '0;
      exp_q.push_back(t);
      l[i*32 +: 32] = rb + 32'(i);
    end
    line_q.push_back(l);
  endtask

  // One transfer; lat counts posedges from the req sample edge to done high.
  task automatic run(input logic wb, input logic [31:0] wa, input logic [31:0] fa,
                     input logic [255:0] line, input int inject_at,
                     output int lt, output int wc);
    push_xfer(wb, wa, fa, line, rd_base);
    @(negedge clk);
    req = 1'b1; wb_en = wb; wb_addr = wa; fill_addr = fa; wb_line = line;
    wc = 0;
    @(posedge clk); lt = 1;
    @(negedge clk); req = 1'b0;
    check("busy_after_req", {255'd0, busy}, {255'd0, 1'b1});
    while (!done && lt < 200) begin
      if (mem_req && mem_we) wc++;
      if (lt == inject_at) begin
        req = 1'b1; wb_en = 1'b1; wb_addr = 32'hDEAD_0000; fill_addr = 32'hBEEF_0040;
        wb_line = '1;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); lt++;
      @(negedge clk);
    end
    check("done_seen", {255'd0, done}, {255'd0, 1'b1});
    @(negedge clk);
    check("done_width", {255'd0, done}, 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset values.
    #2;
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_done", {255'd0, done}, 256'd0);
    check("rst_mem_req", {255'd0, mem_req}, 256'd0);
    check("rst_mem_we", {255'd0, mem_we}, 256'd0);
    check("rst_mem_addr", {224'd0, mem_addr}, 256'd0);
    check("rst_mem_wdata", {224'd0, mem_wdata}, 256'd0);
    check("rst_fill_line", fill_line, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean fill.
    rd_base = 32'h1000_0000;
    run(1'b0, 32'h0, 32'h0000_1234, '0, -1, lat, wbc);
    check("clean_latency", 256'(lat), 256'd9);
    check("clean_wb_cycles", 256'(wbc), 256'd0);

    // Dirty miss.
    rd_base = 32'hA0B0_0000;
    run(1'b1, 32'h0000_2000, 32'h0000_3040,
        256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
        -1, lat, wbc);
    check("dirty_latency", 256'(lat), 256'd17);
    check("dirty_wb_cycles", 256'(wbc), 256'd8);

    // Wait states: 4 cycles per word.
    ack_mode = 1;
    rd_base = 32'h5500_0000;
    run(1'b1, 32'h0000_4004, 32'h0000_5000,
        256'hCAFE0007_CAFE0006_CAFE0005_CAFE0004_CAFE0003_CAFE0002_CAFE0001_CAFE0000,
        -1, lat, wbc);
    check("wait_wb_cycles", 256'(wbc), 256'd32);
    check("wait_latency", 256'(lat), 256'd65);
    ack_mode = 0;
    @(negedge clk);

    // req during FILL is ignored.
    rd_base = 32'h2200_0000;
    d0 = done_cnt;
    run(1'b0, 32'h0, 32'h0000_6000, '0, 3, lat, wbc);
    repeat (20) @(negedge clk);
    check("ignored_req_latency", 256'(lat), 256'd9);
    check("ignored_req_done_count", 256'(done_cnt - d0), 256'd1);

    // Async reset mid-writeback at word 4.
    rd_base = 32'h3300_0000;
    push_xfer(1'b1, 32'h0000_A000, 32'h0000_B000, {8{32'h5A5A_0000}}, rd_base);
    @(negedge clk);
    req = 1'b1; wb_en = 1'b1; wb_addr = 32'h0000_A000; fill_addr = 32'h0000_B000;
    wb_line = {8{32'h5A5A_0000}};
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_addr", {224'd0, mem_addr}, {224'd0, 32'h0000_A010});
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {255'd0, busy}, 256'd0);
    check("mid_rst_mem_req", {255'd0, mem_req}, 256'd0);
    check("mid_rst_mem_we", {255'd0, mem_we}, 256'd0);
    check("mid_rst_mem_addr", {224'd0, mem_addr}, 256'd0);
    check("mid_rst_mem_wdata", {224'd0, mem_wdata}, 256'd0);
    check("mid_rst_done", {255'd0, done}, 256'd0);
    check("mid_rst_fill_line", fill_line, 256'd0);
    exp_q.delete();
    line_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 256'(done_cnt - d0), 256'd0);
    run(1'b1, 32'h0000_A000, 32'h0000_B000,
        256'h0F0F0007_0F0F0006_0F0F0005_0F0F0004_0F0F0003_0F0F0002_0F0F0001_0F0F0000,
        -1, lat, wbc);
    check("restart_latency", 256'(lat), 256'd17);

    // Back-to-back with req held high.
    rd_base = 32'h4400_0000;
    push_xfer(1'b0, 32'h0, 32'h0000_8000, '0, rd_base);
    push_xfer(1'b1, 32'h0000_9000, 32'h0000_9100, {8{32'h1234_5678}}, rd_base);
    @(negedge clk);
    req = 1'b1; wb_en = 1'b0; fill_addr = 32'h0000_8000;
    @(posedge clk); lat = 1;
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 32'h0000_9000; fill_addr = 32'h0000_9100;
    wb_line = {8{32'h1234_5678}};
    while (!done && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check("b2b_first_latency", 256'(lat), 256'd9);
    lat = 0;
    @(posedge clk); lat++;
    @(negedge clk);
    check("b2b_first_width", {255'd0, done}, 256'd0);
    while (!done && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    req = 1'b0;
    check("b2b_gap", 256'(lat), 256'd18);
    @(negedge clk);
    check("b2b_second_width", {255'd0, done}, 256'd0);
    repeat (5) @(negedge clk);
    check("b2b_idle_busy", {255'd0, busy}, 256'd0);

    check("exp_q_drained", 256'(exp_q.size()), 256'd0);
    check("line_q_drained", 256'(line_q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
